// File: rtl/stage3_ex_pkg.sv
// stage3_ex_pkg - bus widths, field offsets, op encodings for the execute stage
package stage3_ex_pkg;
    // Bus widths
    localparam int DS_ES_W = 242;
    localparam int ES_MS_W = 212;
    localparam int ES_DS_W = 55;

    // decode -> EX payload field offsets (LSB positions)
    localparam int DS_PC        = 0;    // 32
    localparam int DS_ALU_OP    = 32;   // 12
    localparam int DS_SRC1      = 44;   // 32
    localparam int DS_SRC2      = 76;   // 32
    localparam int DS_RKD       = 108;  // 32
    localparam int DS_GR_WE     = 140;  // 1
    localparam int DS_DEST      = 141;  // 5
    localparam int DS_LD_OP     = 146;  // 5
    localparam int DS_ST_OP     = 151;  // 3
    localparam int DS_CSR       = 154;  // 1
    localparam int DS_CSR_WRITE = 155;  // 1
    localparam int DS_CSR_NUM   = 156;  // 14
    localparam int DS_CSR_WMASK = 170;  // 32
    localparam int DS_EX        = 202;  // 1
    localparam int DS_ECODE     = 203;  // 6
    localparam int DS_ERTN      = 209;  // 1
    localparam int DS_VADDR     = 210;  // 32

    // EX -> MEM payload field offsets
    localparam int MS_PC        = 0;
    localparam int MS_RESULT    = 32;
    localparam int MS_GR_WE     = 64;
    localparam int MS_DEST      = 65;
    localparam int MS_LD_OP     = 70;
    localparam int MS_FROM_MEM  = 75;
    localparam int MS_UNALIGNED = 76;
    localparam int MS_CSR       = 78;
    localparam int MS_CSR_WRITE = 79;
    localparam int MS_CSR_NUM   = 80;
    localparam int MS_CSR_WMASK = 94;
    localparam int MS_RKD       = 126;
    localparam int MS_EX        = 158;
    localparam int MS_ALE       = 159;
    localparam int MS_ECODE     = 160;
    localparam int MS_ERTN      = 166;
    localparam int MS_VADDR     = 180;

    // ld_op one-hot bits
    localparam int LD_B  = 0;
    localparam int LD_H  = 1;
    localparam int LD_W  = 2;
    localparam int LD_BU = 3;
    localparam int LD_HU = 4;

    // st_op one-hot bits
    localparam int ST_W = 0;
    localparam int ST_B = 1;
    localparam int ST_H = 2;

    // Access size encodings
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // alu_op one-hot bits
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;
endpackage

// File: rtl/stage3_ex_alu.sv
// stage3_ex_alu - one-hot selected 32-bit ALU
// Ports: alu_op (one-hot, 12), src1, src2 -> result. No op selected gives 0.
module stage3_ex_alu
    import stage3_ex_pkg::*;
(
    input  logic [11:0] alu_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] result
);
    logic [31:0] sum;
    logic [31:0] diff;
    logic        slt;

    assign sum  = src1 + src2;
    assign diff = src1 - src2;
    // Signed compare: sign bits differ -> src1 negative wins, else sign of diff
    assign slt  = (src1[31] != src2[31]) ? src1[31] : diff[31];

    always_comb begin
        result = 32'h0;
        if (alu_op[ALU_ADD])  result = result | sum;
        if (alu_op[ALU_SUB])  result = result | diff;
        if (alu_op[ALU_SLT])  result = result | {31'h0, slt};
        if (alu_op[ALU_SLTU]) result = result | {31'h0, (src1 < src2)};
        if (alu_op[ALU_AND])  result = result | (src1 & src2);
        if (alu_op[ALU_NOR])  result = result | ~(src1 | src2);
        if (alu_op[ALU_OR])   result = result | (src1 | src2);
        if (alu_op[ALU_XOR])  result = result | (src1 ^ src2);
        if (alu_op[ALU_SLL])  result = result | (src1 << src2[4:0]);
        if (alu_op[ALU_SRL])  result = result | (src1 >> src2[4:0]);
        if (alu_op[ALU_SRA])  result = result | 32'($signed(src1) >>> src2[4:0]);
        if (alu_op[ALU_LUI])  result = result | src2;
    end
endmodule

// File: rtl/stage3_ex.sv
// stage3_ex - execute stage: ALU, alignment check, data SRAM request
// Ports: clk/reset (sync, active-high); ertn_flush/wb_ex flush; pipeline
// handshake ms_allow_in/es_allow_in/ds_to_es_valid/es_to_ms_valid; payload
// buses ds_to_es_bus, es_to_ms_bus, es_to_ds_bus; if_ms_ex; data_sram_* request.
module stage3_ex
    import stage3_ex_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                ertn_flush,
    input  logic                wb_ex,
    input  logic                ms_allow_in,
    output logic                es_allow_in,
    input  logic                ds_to_es_valid,
    output logic                es_to_ms_valid,
    input  logic [DS_ES_W-1:0]  ds_to_es_bus,
    output logic [ES_MS_W-1:0]  es_to_ms_bus,
    output logic [ES_DS_W-1:0]  es_to_ds_bus,
    input  logic                if_ms_ex,
    output logic                data_sram_req,
    output logic                data_sram_wr,
    output logic [1:0]          data_sram_size,
    output logic [3:0]          data_sram_wstrb,
    output logic [31:0]         data_sram_addr,
    output logic [31:0]         data_sram_wdata,
    input  logic                data_sram_addr_ok
);
    logic               es_valid;
    logic               req_done;
    logic [DS_ES_W-1:0] payload;

    logic [31:0] pc, src1, src2, rkd, csr_wmask, vaddr_in, result, addr;
    logic [11:0] alu_op;
    logic [4:0]  dest, ld_op;
    logic [2:0]  st_op;
    logic [13:0] csr_num;
    logic [5:0]  ecode;
    logic        gr_we, csr, csr_write, ex_in, ertn;
    logic        mem_op, is_word, is_half, ale, es_ex, cancel, flush;
    logic        es_ready_go, handoff, accepted;
    logic [31:0] vaddr;

    assign pc        = payload[DS_PC +: 32];
    assign alu_op    = payload[DS_ALU_OP +: 12];
    assign src1      = payload[DS_SRC1 +: 32];
    assign src2      = payload[DS_SRC2 +: 32];
    assign rkd       = payload[DS_RKD +: 32];
    assign gr_we     = payload[DS_GR_WE];
    assign dest      = payload[DS_DEST +: 5];
    assign ld_op     = payload[DS_LD_OP +: 5];
    assign st_op     = payload[DS_ST_OP +: 3];
    assign csr       = payload[DS_CSR];
    assign csr_write = payload[DS_CSR_WRITE];
    assign csr_num   = payload[DS_CSR_NUM +: 14];
    assign csr_wmask = payload[DS_CSR_WMASK +: 32];
    assign ex_in     = payload[DS_EX];
    assign ecode     = payload[DS_ECODE +: 6];
    assign ertn      = payload[DS_ERTN];
    assign vaddr_in  = payload[DS_VADDR +: 32];

    stage3_ex_alu u_alu (
        .alu_op (alu_op),
        .src1   (src1),
        .src2   (src2),
        .result (result)
    );

    assign addr    = result;
    assign mem_op  = (|ld_op) | (|st_op);
    assign is_word = ld_op[LD_W] | st_op[ST_W];
    assign is_half = ld_op[LD_H] | ld_op[LD_HU] | st_op[ST_H];
    assign ale     = (is_word & (addr[1:0] != 2'b00)) | (is_half & addr[0]);
    assign es_ex   = ex_in | ale;
    assign vaddr   = ale ? addr : vaddr_in;

    assign flush    = ertn_flush | wb_ex;
    assign cancel   = es_ex | if_ms_ex | flush;

    assign data_sram_req = es_valid & mem_op & ~req_done & ~cancel;
    assign accepted      = data_sram_req & data_sram_addr_ok;

    // An excepting instruction (own or older in MEM) moves on without memory
    assign es_ready_go    = ~mem_op | req_done | accepted | es_ex | if_ms_ex;
    assign es_allow_in    = ~es_valid | (es_ready_go & ms_allow_in);
    assign es_to_ms_valid = es_valid & es_ready_go & ~flush;
    assign handoff        = es_to_ms_valid & ms_allow_in;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            es_valid <= 1'b0;
        end else if (es_allow_in) begin
            es_valid <= ds_to_es_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            payload <= '0;
        end else if (ds_to_es_valid && es_allow_in) begin
            payload <= ds_to_es_bus;
        end
    end

    // Handoff takes priority: an instruction accepted and handed off in the
    // same cycle leaves no pending state behind.
    always_ff @(posedge clk) begin
        if (reset || flush || handoff) begin
            req_done <= 1'b0;
        end else if (accepted) begin
            req_done <= 1'b1;
        end
    end

    assign data_sram_wr   = |st_op;
    assign data_sram_addr = addr;

    always_comb begin
        data_sram_size  = SIZE_B;
        data_sram_wstrb = 4'h0;
        data_sram_wdata = 32'h0;
        if (is_word)      data_sram_size = SIZE_W;
        else if (is_half) data_sram_size = SIZE_H;
        if (st_op[ST_W]) begin
            data_sram_wstrb = 4'hF;
            data_sram_wdata = rkd;
        end else if (st_op[ST_H]) begin
            data_sram_wstrb = 4'b0011 << {addr[1], 1'b0};
            data_sram_wdata = {2{rkd[15:0]}};
        end else if (st_op[ST_B]) begin
            data_sram_wstrb = 4'b0001 << addr[1:0];
            data_sram_wdata = {4{rkd[7:0]}};
        end
    end

    assign es_to_ms_bus = {vaddr, 13'h0, ertn, ecode, ale, es_ex, rkd, csr_wmask,
                           csr_num, csr_write, csr, addr[1:0], |ld_op, ld_op,
                           dest, gr_we, result, pc};

    assign es_to_ds_bus = {es_valid & gr_we, dest, result, |ld_op, csr_write,
                           csr_num, csr};
endmodule

// File: tb/tb_stage3_ex.sv
// tb/tb_stage3_ex.sv - directed self-checking bench for stage3_ex
module tb_stage3_ex;
    import stage3_ex_pkg::*;

    logic               clk = 1'b0;
    logic               reset, ertn_flush, wb_ex, ms_allow_in, ds_to_es_valid;
    logic               if_ms_ex, data_sram_addr_ok;
    logic [DS_ES_W-1:0] ds_to_es_bus;
    logic               es_allow_in, es_to_ms_valid;
    logic [ES_MS_W-1:0] es_to_ms_bus;
    logic [ES_DS_W-1:0] es_to_ds_bus;
    logic               data_sram_req, data_sram_wr;
    logic [1:0]         data_sram_size;
    logic [3:0]         data_sram_wstrb;
    logic [31:0]        data_sram_addr, data_sram_wdata;

    int checks = 0;
    int errors = 0;
    int acc    = 0;
    int acc0;

    always #5 clk = ~clk;

    always @(posedge clk) if (data_sram_req && data_sram_addr_ok) acc <= acc + 1;

    stage3_ex dut (
        .clk(clk), .reset(reset), .ertn_flush(ertn_flush), .wb_ex(wb_ex),
        .ms_allow_in(ms_allow_in), .es_allow_in(es_allow_in),
        .ds_to_es_valid(ds_to_es_valid), .es_to_ms_valid(es_to_ms_valid),
        .ds_to_es_bus(ds_to_es_bus), .es_to_ms_bus(es_to_ms_bus),
        .es_to_ds_bus(es_to_ds_bus), .if_ms_ex(if_ms_ex),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok)
    );

    task automatic chk(input string tag, input logic [ES_MS_W-1:0] obs,
                       input logic [ES_MS_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [DS_ES_W-1:0] mk(input logic [31:0] pc,
            input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rkd,
            input logic we, input logic [4:0] dest, input logic [4:0] ld,
            input logic [2:0] st);
        logic [DS_ES_W-1:0] b;
        b = '0;
        b[DS_PC +: 32]     = pc;
        b[DS_ALU_OP +: 12] = 12'h001;  // add
        b[DS_SRC1 +: 32]   = s1;
        b[DS_SRC2 +: 32]   = s2;
        b[DS_RKD +: 32]    = rkd;
        b[DS_GR_WE]        = we;
        b[DS_DEST +: 5]    = dest;
        b[DS_LD_OP +: 5]   = ld;
        b[DS_ST_OP +: 3]   = st;
        return b;
    endfunction

    task automatic issue(input logic [DS_ES_W-1:0] b);
        ds_to_es_bus   = b;
        ds_to_es_valid = 1'b1;
        tick();
        ds_to_es_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ertn_flush = 1'b0; wb_ex = 1'b0; ms_allow_in = 1'b1;
        ds_to_es_valid = 1'b0; if_ms_ex = 1'b0; data_sram_addr_ok = 1'b0;
        ds_to_es_bus = '0;

        // 1. reset
        tick(); tick();
        chk("rst_allow_in", es_allow_in, 1);
        chk("rst_ms_valid", es_to_ms_valid, 0);
        chk("rst_req", data_sram_req, 0);
        chk("rst_wr_size_wstrb", {data_sram_wr, data_sram_size, data_sram_wstrb}, 0);
        chk("rst_addr_wdata", {data_sram_addr, data_sram_wdata}, 0);
        chk("rst_ms_bus", es_to_ms_bus, 0);
        chk("rst_ds_bus", es_to_ds_bus, 0);
        reset = 1'b0;
        tick();

        // 2. ld_w at 0x1000, addr_ok two cycles late
        issue(mk(32'h40, 32'h0FF0, 32'h10, 0, 1'b1, 5'd3, 5'b00100, 3'b000));
        settle();
        chk("ldw_req_c1", data_sram_req, 1);
        chk("ldw_size", data_sram_size, 2);
        chk("ldw_wstrb", data_sram_wstrb, 0);
        chk("ldw_addr", data_sram_addr, 32'h1000);
        chk("ldw_msv_c1", es_to_ms_valid, 0);
        tick(); settle();
        chk("ldw_req_c2", data_sram_req, 1);
        chk("ldw_msv_c2", es_to_ms_valid, 0);
        tick();
        data_sram_addr_ok = 1'b1;
        settle();
        chk("ldw_req_c3", data_sram_req, 1);
        chk("ldw_msv_c3", es_to_ms_valid, 1);
        chk("ldw_from_mem", es_to_ms_bus[MS_FROM_MEM], 1);
        chk("ldw_result", es_to_ms_bus[MS_RESULT +: 32], 32'h1000);
        chk("ldw_fwd", es_to_ds_bus, {1'b1, 5'd3, 32'h1000, 1'b1, 1'b0, 14'h0, 1'b0});
        tick();
        data_sram_addr_ok = 1'b0;
        settle();
        chk("ldw_req_after", data_sram_req, 0);
        chk("ldw_msv_after", es_to_ms_valid, 0);
        chk("ldw_one_accept", acc, 1);

        // 3. st_h at 0x1002
        issue(mk(32'h44, 32'h1000, 32'h2, 32'h1234ABCD, 1'b0, 5'd0, 5'b0, 3'b100));
        data_sram_addr_ok = 1'b1;
        settle();
        chk("sth_wstrb", data_sram_wstrb, 4'b1100);
        chk("sth_wdata", data_sram_wdata, 32'hABCDABCD);
        chk("sth_wr_size", {data_sram_wr, data_sram_size}, {1'b1, 2'd1});
        chk("sth_req_msv", {data_sram_req, es_to_ms_valid}, 2'b11);
        tick();
        data_sram_addr_ok = 1'b0;

        // st_b at 0x1003
        issue(mk(32'h48, 32'h1000, 32'h3, 32'h000000EF, 1'b0, 5'd0, 5'b0, 3'b010));
        data_sram_addr_ok = 1'b1;
        settle();
        chk("stb_wstrb", data_sram_wstrb, 4'b1000);
        chk("stb_wdata", data_sram_wdata, 32'hEFEFEFEF);
        chk("stb_size", data_sram_size, 0);
        tick();
        data_sram_addr_ok = 1'b0;
        chk("st_accepts", acc, 3);

        // 4. ld_w at 0x1001 -> ALE
        issue(mk(32'h4C, 32'h1000, 32'h1, 0, 1'b1, 5'd4, 5'b00100, 3'b000));
        settle();
        chk("ale_req", data_sram_req, 0);
        chk("ale_msv", es_to_ms_valid, 1);
        chk("ale_flags", {es_to_ms_bus[MS_ALE], es_to_ms_bus[MS_EX]}, 2'b11);
        chk("ale_vaddr", es_to_ms_bus[MS_VADDR +: 32], 32'h1001);
        chk("ale_unaligned", es_to_ms_bus[MS_UNALIGNED +: 2], 2'b01);
        tick(); settle();
        chk("ale_gone", es_to_ms_valid, 0);

        // 5a. st_w while MEM holds an exception
        if_ms_ex = 1'b1;
        issue(mk(32'h50, 32'h2000, 32'h0, 32'h55, 1'b0, 5'd0, 5'b0, 3'b001));
        settle();
        chk("msex_req", data_sram_req, 0);
        chk("msex_msv", es_to_ms_valid, 1);
        chk("msex_ale", es_to_ms_bus[MS_ALE], 0);
        tick();
        if_ms_ex = 1'b0;
        chk("msex_no_accept", acc, 3);

        // 5b. wb_ex while a store request is pending
        issue(mk(32'h54, 32'h2000, 32'h4, 32'h66, 1'b0, 5'd0, 5'b0, 3'b001));
        settle();
        chk("wbex_req_pre", data_sram_req, 1);
        wb_ex = 1'b1;
        settle();
        chk("wbex_req_flush", data_sram_req, 0);
        chk("wbex_msv_flush", es_to_ms_valid, 0);
        tick();
        wb_ex = 1'b0;
        settle();
        chk("wbex_after", {es_allow_in, es_to_ms_valid, data_sram_req}, 3'b100);
        chk("wbex_bus_clr", es_to_ms_bus, 0);
        chk("wbex_no_accept", acc, 3);

        // 6. MEM stalls after addr_ok
        acc0 = acc;
        ms_allow_in = 1'b0;
        issue(mk(32'h80, 32'h3000, 32'h0, 0, 1'b1, 5'd5, 5'b00100, 3'b000));
        data_sram_addr_ok = 1'b1;
        settle();
        chk("stall_req_c1", data_sram_req, 1);
        chk("stall_allow_c1", es_allow_in, 0);
        tick(); settle();
        chk("stall_req_c2", data_sram_req, 0);
        chk("stall_allow_c2", es_allow_in, 0);
        chk("stall_msv_c2", es_to_ms_valid, 1);
        chk("stall_pc_c2", es_to_ms_bus[MS_PC +: 32], 32'h80);
        tick(); tick(); settle();
        chk("stall_req_c4", data_sram_req, 0);
        chk("stall_pc_c4", es_to_ms_bus[MS_PC +: 32], 32'h80);
        chk("stall_fwd", es_to_ds_bus[54:49], {1'b1, 5'd5});
        ms_allow_in = 1'b1;
        settle();
        chk("stall_release", {es_to_ms_valid, es_allow_in}, 2'b11);
        tick();
        data_sram_addr_ok = 1'b0;
        settle();
        chk("stall_gone", es_to_ms_valid, 0);
        chk("stall_single_req", acc - acc0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
